fetch_align_buffer: RTL and testbench

- Instruction-fetch front end that prefetches 32-bit words from instruction memory.
- Tracks the halfword-granular PC and realigns the 16/32-bit instruction stream, then presents one instruction per handshake to the compressed expander and decode stage.
- Handles 32-bit instructions that straddle word boundaries, branch/jump redirects, and discarding of in-flight responses.

---
 rtl/fetch_align_buffer_if.sv | 38 +++
 rtl/fetch_align_buffer.sv | 146 ++++++++++++++
 tb/tb_fetch_align_buffer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_align_buffer_if.sv
// Bus bundle for fetch_align_buffer: redirect, instruction-memory and decode handshakes.
// With FETCH_ERR_EN defined it also carries the bus error input and per-instruction error output.
interface fetch_align_buffer_if;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_data_o;
    logic [31:0] instr_pc_o;
    logic        instr_is_c_o;
`ifdef FETCH_ERR_EN
    logic        imem_err_i;
    logic        instr_err_o;
`endif

    modport master (
`ifdef FETCH_ERR_EN
        input  imem_err_i,
        output instr_err_o,
`endif
        input  flush_i, flush_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
        output imem_req_o, imem_addr_o, instr_valid_o, instr_data_o, instr_pc_o, instr_is_c_o
    );

    modport slave (
`ifdef FETCH_ERR_EN
        output imem_err_i,
        input  instr_err_o,
`endif
        output flush_i, flush_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
        input  imem_req_o, imem_addr_o, instr_valid_o, instr_data_o, instr_pc_o, instr_is_c_o
    );
endinterface

// File: rtl/fetch_align_buffer.sv
// Instruction fetch/align buffer: prefetches 32-bit words and presents one 16/32-bit instruction
// per handshake. Optional macro FETCH_ERR_EN adds per-word bus error tracking (instr_err_o).
module fetch_align_buffer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    fetch_align_buffer_if.master bus
);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int CW1 = CW + 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
    localparam logic [CW:0]   DEPTH_W  = CW1'(FIFO_DEPTH);

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_e;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_nxt_s;
    logic [CW-1:0] count_q, count_d, outst_q, outst_d, disc_q, disc_d;
    logic [31:0]   pc_q, pc_d, fetch_q, fetch_d;
    logic          req_en_q;
    state_e        state_q, state_d;

    logic [31:0] head_s, next_s, data_s;
    logic [15:0] half_s;
    logic        is_c_s, straddle_s, valid_s, consume_s;
    logic        fits_s, req_s, gnt_s, rvalid_s, push_s, pop_s;
    logic        unused_ok_s;

    // Realign the instruction at pc from the FIFO head (and the next word for a straddle).
    always_comb begin
        rd_nxt_s   = ptr_inc(rd_ptr_q);
        head_s     = mem_q[rd_ptr_q];
        next_s     = mem_q[rd_nxt_s];
        half_s     = pc_q[1] ? head_s[31:16] : head_s[15:0];
        is_c_s     = (half_s[1:0] != 2'b11);
        straddle_s = pc_q[1] & (head_s[17:16] == 2'b11);
        if (is_c_s) begin
            data_s  = {16'h0000, half_s};
            valid_s = (count_q != {CW{1'b0}});
        end else if (straddle_s) begin
            data_s  = {next_s[15:0], head_s[31:16]};
            valid_s = (count_q >= CW'(2));
        end else begin
            data_s  = head_s;
            valid_s = (count_q != {CW{1'b0}});
        end
        consume_s = valid_s & bus.instr_ready_i;
    end

    // Request/response bookkeeping and next-state for pointers, pc, fetch address and discard count.
    always_comb begin
        fits_s   = ({1'b0, count_q} + {1'b0, outst_q}) < DEPTH_W;
        req_s    = req_en_q & fits_s & ~bus.flush_i;
        gnt_s    = req_s & bus.imem_gnt_i;
        rvalid_s = bus.imem_rvalid_i & (outst_q != {CW{1'b0}});
        push_s   = rvalid_s & (state_q == ST_RUN) & ~bus.flush_i;
        pop_s    = consume_s & ~bus.flush_i & (~is_c_s | pc_q[1]);
        outst_d  = outst_q + CW'(gnt_s) - CW'(rvalid_s);
        if (bus.flush_i) begin
            count_d  = {CW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            wr_ptr_d = {PW{1'b0}};
            pc_d     = {bus.flush_pc_i[31:1], 1'b0};
            fetch_d  = {bus.flush_pc_i[31:2], 2'b00};
            disc_d   = outst_d;
        end else begin
            count_d  = count_q + CW'(push_s) - CW'(pop_s);
            rd_ptr_d = pop_s ? rd_nxt_s : rd_ptr_q;
            wr_ptr_d = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
            pc_d     = consume_s ? (pc_q + (is_c_s ? 32'd2 : 32'd4)) : pc_q;
            fetch_d  = gnt_s ? (fetch_q + 32'd4) : fetch_q;
            disc_d   = (rvalid_s && (state_q == ST_DRAIN)) ? (disc_q - CW'(1)) : disc_q;
        end
        state_d = (disc_d != {CW{1'b0}}) ? ST_DRAIN : ST_RUN;
    end

    // Control registers and RUN/DRAIN state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= {PW{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
            outst_q  <= {CW{1'b0}};
            disc_q   <= {CW{1'b0}};
            pc_q     <= RESET_PC;
            fetch_q  <= {RESET_PC[31:2], 2'b00};
            req_en_q <= 1'b0;
            state_q  <= ST_RUN;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            outst_q  <= outst_d;
            disc_q   <= disc_d;
            pc_q     <= pc_d;
            fetch_q  <= fetch_d;
            req_en_q <= 1'b1;
            state_q  <= state_d;
        end
    end

    // Prefetch word storage; cleared on reset so instr_data_o starts at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= bus.imem_rdata_i;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

`ifdef FETCH_ERR_EN
    logic [FIFO_DEPTH-1:0] err_q;

    // Per-word bus error flag, written alongside the data word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= {FIFO_DEPTH{1'b0}};
        end else if (push_s) begin
            err_q[wr_ptr_q] <= bus.imem_err_i;
        end else begin
            err_q <= err_q;
        end
    end

    assign bus.instr_err_o = straddle_s ? (err_q[rd_ptr_q] | err_q[rd_nxt_s]) : err_q[rd_ptr_q];
`endif

    assign bus.imem_req_o    = req_s;
    assign bus.imem_addr_o   = fetch_q;
    assign bus.instr_valid_o = valid_s;
    assign bus.instr_data_o  = data_s;
    assign bus.instr_pc_o    = pc_q;
    assign bus.instr_is_c_o  = is_c_s;
    assign unused_ok_s       = ^{bus.flush_pc_i[0], next_s[31:16]};
endmodule

// File: tb/tb_fetch_align_buffer.sv
// Directed bench for fetch_align_buffer: cycle vector table plus hand sequences for
// back-pressure fill/release and asynchronous reset in the middle of a burst.
module tb_fetch_align_buffer;
    localparam int DEPTH = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    fetch_align_buffer_if bus ();

    fetch_align_buffer #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic [31:0] fpc;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_data;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vt [35];

    function automatic vec_t mk(input logic fl, input logic [31:0] fpc, input logic gnt, input logic rv,
                                input logic [31:0] rd, input logic rdy, input logic req,
                                input logic [31:0] addr, input logic vld, input logic [31:0] dat,
                                input logic [31:0] pc);
        vec_t v;
        v.flush = fl; v.fpc = fpc; v.gnt = gnt; v.rv = rv; v.rdata = rd; v.rdy = rdy;
        v.e_req = req; v.e_addr = addr; v.e_valid = vld; v.e_data = dat; v.e_pc = pc;
        return v;
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[23:0], 8'h13};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic [31:0] fpc, input logic gnt, input logic rv,
                         input logic [31:0] rd, input logic rdy);
        bus.flush_i       = fl;
        bus.flush_pc_i    = fpc;
        bus.imem_gnt_i    = gnt;
        bus.imem_rvalid_i = rv;
        bus.imem_rdata_i  = rd;
        bus.instr_ready_i = rdy;
`ifdef FETCH_ERR_EN
        bus.imem_err_i    = 1'b0;
`endif
    endtask

    task automatic check_out(input string tag, input logic req, input logic [31:0] addr,
                             input logic vld, input logic [31:0] dat, input logic [31:0] pc);
        logic [31:0] d;
        d = dat;
        chk({tag, ".req"},   bus.imem_req_o,    req);
        chk({tag, ".addr"},  bus.imem_addr_o,   addr);
        chk({tag, ".valid"}, bus.instr_valid_o, vld);
        chk({tag, ".pc"},    bus.instr_pc_o,    pc);
        if (vld) begin
            chk({tag, ".data"}, bus.instr_data_o, d);
            chk({tag, ".is_c"}, bus.instr_is_c_o, (d[1:0] != 2'b11));
        end
        chk({tag, ".no_push_full"}, (dut.push_s && (dut.count_q == DEPTH)), 1'b0);
    endtask

    task automatic run_vec(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(posedge clk); #1;
            drive(vt[i].flush, vt[i].fpc, vt[i].gnt, vt[i].rv, vt[i].rdata, vt[i].rdy);
            #4;
            check_out($sformatf("v%0d", i), vt[i].e_req, vt[i].e_addr, vt[i].e_valid,
                      vt[i].e_data, vt[i].e_pc);
        end
    endtask

    initial begin
        logic        rv_nx;
        logic [31:0] ad_nx;
        logic [31:0] exp_pc;

        // Steady stream of 32-bit words from address 0
        vt[0]  = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h00, 1'b0, 32'h0,  32'h00);
        vt[1]  = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h13,       1'b1, 1'b1, 32'h04, 1'b0, 32'h0,  32'h00);
        vt[2]  = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h13,       1'b1, 1'b1, 32'h08, 1'b1, 32'h13, 32'h00);
        vt[3]  = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h13,       1'b1, 1'b1, 32'h0C, 1'b1, 32'h13, 32'h04);
        vt[4]  = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h13,       1'b1, 1'b1, 32'h10, 1'b1, 32'h13, 32'h08);
        vt[5]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h13,       1'b1, 1'b1, 32'h14, 1'b1, 32'h13, 32'h0C);
        vt[6]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h14, 1'b1, 32'h13, 32'h10);
        vt[7]  = mk(1'b1, 32'h40, 1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 32'h14, 1'b0, 32'h0,  32'h14);
        // Two compressed instructions in one word
        vt[8]  = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h40, 1'b0, 32'h0,    32'h40);
        vt[9]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h45014505, 1'b1, 1'b1, 32'h44, 1'b0, 32'h0,    32'h40);
        vt[10] = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h44, 1'b1, 32'h4505, 32'h40);
        vt[11] = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h44, 1'b1, 32'h4501, 32'h42);
        vt[12] = mk(1'b1, 32'h48, 1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 32'h44, 1'b0, 32'h0,    32'h44);
        // Compressed then a 32-bit instruction straddling two words
        vt[13] = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h48, 1'b0, 32'h0,    32'h48);
        vt[14] = mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h00134505, 1'b1, 1'b1, 32'h4C, 1'b0, 32'h0,    32'h48);
        vt[15] = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4C, 1'b1, 32'h4505, 32'h48);
        vt[16] = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h50, 1'b0, 32'h0,    32'h4A);
        vt[17] = mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h11110000, 1'b1, 1'b1, 32'h50, 1'b0, 32'h0,    32'h4A);
        vt[18] = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h50, 1'b1, 32'h13,   32'h4A);
        vt[19] = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h50, 1'b1, 32'h13,   32'h4A);
        vt[20] = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h50, 1'b1, 32'h1111, 32'h4E);
        vt[21] = mk(1'b1, 32'h80, 1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h50, 1'b1, 32'h1111, 32'h4E);
        // Flush with two requests in flight: both responses are stale
        vt[22] = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h80,  1'b0, 32'h0,    32'h80);
        vt[23] = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h84,  1'b0, 32'h0,    32'h80);
        vt[24] = mk(1'b1, 32'h103, 1'b1, 1'b0, 32'h0,      1'b0, 1'b0, 32'h88,  1'b0, 32'h0,    32'h80);
        vt[25] = mk(1'b0, 32'h0, 1'b0, 1'b1, 32'hAAAAAAAA, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0,    32'h102);
        vt[26] = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'hBBBBBBBB, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0,    32'h102);
        vt[27] = mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h44090001, 1'b1, 1'b1, 32'h104, 1'b0, 32'h0,    32'h102);
        vt[28] = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h104, 1'b1, 32'h4409, 32'h102);
        vt[29] = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h104, 1'b0, 32'h0,    32'h104);
        // After mid-burst reset: late response ignored, fresh fetch from 0
        vt[30] = mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h55555557, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0,  32'h00);
        vt[31] = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h00, 1'b0, 32'h0,  32'h00);
        vt[32] = mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h13,       1'b1, 1'b1, 32'h04, 1'b0, 32'h0,  32'h00);
        vt[33] = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h04, 1'b1, 32'h13, 32'h00);
        vt[34] = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h04, 1'b0, 32'h0,  32'h04);

        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        check_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        chk("reset.data", bus.instr_data_o, 32'h0);
        rst_n = 1'b1;

        run_vec(0, 29);

        // Decode stalled: buffer fills, requests stop, presented instruction holds
        rv_nx = 1'b0;
        ad_nx = 32'h0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            drive(1'b0, 32'h0, 1'b1, rv_nx, word_of(ad_nx), 1'b0);
            #4;
            rv_nx = bus.imem_req_o & bus.imem_gnt_i;
            ad_nx = bus.imem_addr_o;
            if (i >= 2) begin
                chk($sformatf("hold%0d.valid", i), bus.instr_valid_o, 1'b1);
                chk($sformatf("hold%0d.pc", i),    bus.instr_pc_o,    32'h104);
                chk($sformatf("hold%0d.data", i),  bus.instr_data_o,  32'h0001_0413);
            end
            if (i >= 4) begin
                chk($sformatf("hold%0d.req", i),  bus.imem_req_o,  1'b0);
                chk($sformatf("hold%0d.addr", i), bus.imem_addr_o, 32'h110);
            end
        end

        // Release: one instruction per cycle, strictly in order
        exp_pc = 32'h104;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            drive(1'b0, 32'h0, 1'b1, rv_nx, word_of(ad_nx), 1'b1);
            #4;
            rv_nx = bus.imem_req_o & bus.imem_gnt_i;
            ad_nx = bus.imem_addr_o;
            chk($sformatf("run%0d.valid", i), bus.instr_valid_o, 1'b1);
            chk($sformatf("run%0d.pc", i),    bus.instr_pc_o,    exp_pc);
            chk($sformatf("run%0d.data", i),  bus.instr_data_o,  word_of(exp_pc));
            chk($sformatf("run%0d.no_push_full", i), (dut.push_s && (dut.count_q == DEPTH)), 1'b0);
            exp_pc = exp_pc + 32'd4;
        end

        // Reset while a request is pending and a response is in flight
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 1'b0, rv_nx, word_of(ad_nx), 1'b1);
        #1;
        chk("burst.req_pending", bus.imem_req_o, 1'b1);
        rst_n = 1'b0;
        #1;
        check_out("midrst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        chk("midrst.data", bus.instr_data_o, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h55555557, 1'b1);
        #3;
        chk("release.req",   bus.imem_req_o,    1'b0);
        chk("release.valid", bus.instr_valid_o, 1'b0);

        run_vec(30, 34);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
